// File: rtl/ram_line_responder.sv
// Memory-side responder for the cache RAM port: single-word writes and latency-delayed line-fill bursts.
// Optional write/read parity checking is enabled by defining RAM_RESP_PARITY_EN.
module ram_line_responder #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 3
) (
  input  logic                          globalclock,
  input  logic                          reset,
  input  logic                          req,
  input  logic                          wr,
  input  logic [ADDR_W-1:0]             address,
  input  logic [DATA_W-1:0]             wdata,
`ifdef RAM_RESP_PARITY_EN
  input  logic                          wpar,
  output logic                          rpar,
`endif
  output logic                          ack,
  output logic                          busy,
  output logic                          rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic [$clog2(LINE_WORDS)-1:0] beat,
  output logic                          last
);

  localparam int BW = $clog2(LINE_WORDS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  localparam logic [3:0]    WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  logic [1:0]        state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_ok_q;

  logic                 wr_ok;
  logic                 issue;
  logic [BW-1:0]        issue_beat;
  logic [ADDR_W-BW-1:0] issue_line;
  logic [DATA_W-1:0]    rd_word;

  // A write whose parity disagrees with its data is acknowledged but never stored.
`ifdef RAM_RESP_PARITY_EN
  assign wr_ok = (wpar == ^wdata);
`else
  assign wr_ok = 1'b1;
`endif

  // Decide whether a beat is presented at the coming edge, and which word it carries.
  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    issue      = 1'b0;
    issue_beat = '0;
    issue_line = addr_q[ADDR_W-1:BW];
    case (state)
      ST_IDLE: begin
        if (req && !wr && (LATENCY == 0)) begin
          issue      = 1'b1;
          issue_line = address[ADDR_W-1:BW];
        end
      end
      ST_WAIT:  issue = (wait_cnt == 4'd0);
      ST_BURST: begin
        if (beat != LAST_BEAT) begin
          issue      = 1'b1;
          issue_beat = beat + BW'(1);
        end
      end
      default: ;
    endcase
  end

  assign rd_word = mem[{issue_line, issue_beat}];

  // NOTE: the array has no reset; its contents must survive reset, and that keeps it mappable to block RAM.
  always_ff @(posedge globalclock) begin
    if (state == ST_WRITE && wr_ok_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge globalclock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_ok_q  <= 1'b0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      beat     <= '0;
      last     <= 1'b0;
`ifdef RAM_RESP_PARITY_EN
      rpar     <= 1'b0;
`endif
    end else begin
      ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            ack     <= 1'b1;
            busy    <= 1'b1;
            wdata_q <= wdata;
            wr_ok_q <= wr_ok;
            if (wr) begin
              addr_q <= address;
              state  <= ST_WRITE;
            end else begin
              // Reads always start at the line base so a burst never crosses a line.
              addr_q <= {address[ADDR_W-1:BW], {BW{1'b0}}};
              if (LATENCY == 0) begin
                state <= ST_BURST;
              end else begin
                state    <= ST_WAIT;
                wait_cnt <= WAIT_LOAD;
              end
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_BURST;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_BURST: begin
          if (beat == LAST_BEAT) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            rvalid <= 1'b0;
            last   <= 1'b0;
          end
        end
        ST_WRITE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      if (issue) begin
        rvalid <= 1'b1;
        beat   <= issue_beat;
        last   <= (issue_beat == LAST_BEAT);
        rdata  <= rd_word;
`ifdef RAM_RESP_PARITY_EN
        rpar   <= ^rd_word;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ram_line_responder.sv
// Self-checking bench for ram_line_responder: directed and randomized traffic against a word-level memory model.
`timescale 1ns/1ps
module tb_ram_line_responder;

  localparam int AW  = 15;
  localparam int DW  = 8;
  localparam int LW  = 4;
  localparam int LAT = 3;
`ifdef RAM_RESP_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  clk_en = 1'b1;
  logic                  reset;
  logic                  req;
  logic                  wr;
  logic [AW-1:0]         address;
  logic [DW-1:0]         wdata;
  logic                  ack;
  logic                  busy;
  logic                  rvalid;
  logic [DW-1:0]         rdata;
  logic [$clog2(LW)-1:0] beat;
  logic                  last;
`ifdef RAM_RESP_PARITY_EN
  logic                  wpar;
  logic                  rpar;
`endif

  int tests = 0;
  int fails = 0;

  // Expected memory contents, keyed by word address; only words the bench has written are known.
  logic [DW-1:0] model [int];

  ram_line_responder #(
    .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .LATENCY(LAT)
  ) dut (
    .globalclock(clk),
    .reset(reset),
    .req(req),
    .wr(wr),
    .address(address),
    .wdata(wdata),
`ifdef RAM_RESP_PARITY_EN
    .wpar(wpar),
    .rpar(rpar),
`endif
    .ack(ack),
    .busy(busy),
    .rvalid(rvalid),
    .rdata(rdata),
    .beat(beat),
    .last(last)
  );

  always #5 clk = clk_en ? ~clk : clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_beat"}, beat, 0);
    check({tag, "_last"}, last, 0);
`ifdef RAM_RESP_PARITY_EN
    check({tag, "_rpar"}, rpar, 0);
`endif
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic par);
    req = 1'b1; wr = 1'b1; address = a; wdata = d;
`ifdef RAM_RESP_PARITY_EN
    wpar = par;
`endif
    tick();
    req = 1'b0;
    check("wr_ack", ack, 1);
    check("wr_busy", busy, 1);
    tick();
    check("wr_ack_drop", ack, 0);
    check("wr_busy_drop", busy, 0);
    if (!PARITY || (par == ^d)) model[int'(a)] = d;
  endtask

  // Read accepted at edge 0: ack in cycle 1, beats in cycles LAT+1..LAT+LW, idle after.
  // With noise set, req/wr/address are scrambled while busy; none of it may be accepted.
  task automatic do_read(input logic [AW-1:0] a, input bit noise);
    int base;
    base = int'(a) - (int'(a) % LW);
    req = 1'b1; wr = 1'b0; address = a;
    for (int c = 1; c <= LAT + LW + 1; c++) begin
      int b;
      tick();
      req = 1'b0;
      if (c == 1) check("rd_ack", ack, 1);
      else        check("rd_ack_quiet", ack, 0);
      check("rd_busy", busy, (c <= LAT + LW) ? 1 : 0);
      if (c > LAT && c <= LAT + LW) begin
        b = c - LAT - 1;
        check("rd_rvalid", rvalid, 1);
        check("rd_beat", beat, b);
        check("rd_last", last, (b == LW - 1) ? 1 : 0);
        if (model.exists(base + b)) begin
          check("rd_rdata", rdata, model[base + b]);
`ifdef RAM_RESP_PARITY_EN
          check("rd_rpar", rpar, ^model[base + b]);
`endif
        end
      end else begin
        check("rd_rvalid_off", rvalid, 0);
        check("rd_last_off", last, 0);
      end
      if (noise && c < LAT + LW + 1) begin
        req     = 1'($urandom_range(0, 1));
        wr      = 1'($urandom_range(0, 1));
        address = AW'($urandom);
        wdata   = DW'($urandom);
      end
    end
    req = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [AW-1:0] a;

    reset = 1'b0; req = 1'b0; wr = 1'b0; address = '0; wdata = '0;
`ifdef RAM_RESP_PARITY_EN
    wpar = 1'b0;
`endif
    repeat (2) tick();
    check_cleared("por");
    reset = 1'b1;
    tick();

    // Known contents for the low window and the top line.
    for (int i = 0; i < 64; i++) begin
      d = DW'($urandom);
      do_write(AW'(i), d, ^d);
    end
    for (int i = 0; i < LW; i++) begin
      d = DW'($urandom);
      do_write(AW'(32'h7FFC + i), d, ^d);
    end

    // Write then line read; beat 1 must return 0xA5.
    d = 8'hA5;
    do_write(15'h0005, d, ^d);
    do_read(15'h0004, 1'b0);

    // Unaligned reads, including the top line which must not wrap.
    do_read(15'h0007, 1'b0);
    do_read(15'h7FFE, 1'b0);

    // Requests while busy are ignored.
    do_read(15'h0008, 1'b1);
    repeat (3) begin
      tick();
      check("post_noise_ack", ack, 0);
      check("post_noise_busy", busy, 0);
    end

    // Back-to-back: req held through burst end, second ack two cycles after the last beat.
    req = 1'b1; wr = 1'b0; address = 15'h0010;
    tick();
    check("b2b_ack1", ack, 1);
    repeat (LAT + LW - 1) tick();
    check("b2b_last1", last, 1);
    tick();
    check("b2b_gap_ack", ack, 0);
    check("b2b_gap_busy", busy, 0);
    tick();
    check("b2b_ack2", ack, 1);
    req = 1'b0;
    repeat (LAT + LW - 1) tick();
    check("b2b_last2", last, 1);
    check("b2b_rdata2", rdata, model[32'h13]);
    tick();
    check("b2b_done_busy", busy, 0);

    // Reset at beat 1 with the clock stopped: outputs clear at once.
    req = 1'b1; wr = 1'b0; address = 15'h0016;
    tick();
    req = 1'b0;
    repeat (LAT + 1) tick();
    check("mid_beat", beat, 1);
    check("mid_rvalid", rvalid, 1);
    clk_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_cleared("mid_rst");
    #10;
    reset = 1'b1;
    #3;
    clk_en = 1'b1;
    repeat (LW) begin
      tick();
      check("after_rst_rvalid", rvalid, 0);
    end
    do_read(15'h0016, 1'b0);

    // Reset low at the WRITE-exit edge suppresses the write.
    d = ~model[32'h20];
    req = 1'b1; wr = 1'b1; address = 15'h0020; wdata = d;
`ifdef RAM_RESP_PARITY_EN
    wpar = ^d;
`endif
    tick();
    req = 1'b0;
    check("wrst_ack", ack, 1);
    #1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("wrst_busy", busy, 0);
    do_read(15'h0020, 1'b0);

`ifdef RAM_RESP_PARITY_EN
    do_write(15'h0010, 8'h03, 1'b1);
    do_read(15'h0010, 1'b0);
    do_write(15'h0010, 8'h03, 1'b0);
    do_read(15'h0010, 1'b0);
`endif

    // Randomized mix of writes and reads over the known region.
    repeat (24) begin
      if ($urandom_range(0, 4) == 0) a = AW'(32'h7FFC + $urandom_range(0, LW - 1));
      else                           a = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) begin
        d = DW'($urandom);
        do_write(a, d, ^d);
      end else begin
        do_read(a, 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
